mv_job_sequencer: RTL and testbench
===================================

// Module: mv_job_sequencer
// PURPOSE
//  Host-side initiator for the mat-vec Controller's running/width/iteration/finish handshake.
//  Queues job descriptors, launches them one at a time and holds the operands stable.
//  Drops running after finish and enforces an idle gap between jobs.
//  Reports each job's cycle count or error status on a valid/ready result port.
//  Sits between the AXI-lite register slice and the Controller in the fixed_mv IP.
// PARAMETERS
//  QDEPTH_LOG2     2   job FIFO depth = 2**QDEPTH_LOG2 entries
//  WIDTH_BITS      9   width field, matches Controller width port
//  ITER_BITS       16  iteration field, matches Controller iteration port
//  CYC_BITS        32  run-cycle counter width, saturating
//  GAP_CYCLES      2   minimum cycles running stays low between jobs (>=1)
//  TIMEOUT_CYCLES  0   run-cycle limit; 0 disables the timeout
// PORTS
//  clk            in   1            single clock domain
//  rstn           in   1            asynchronous, active-low reset
//  job_valid      in   1            job descriptor offered
//  job_ready      out  1            FIFO not full; push when job_valid&job_ready
//  job_width      in   WIDTH_BITS   matrix width of the job
//  job_iteration  in   ITER_BITS    iteration count of the job
//  abort          in   1            synchronous cancel: current job and queue
//  running        out  1            to Controller.running
//  width          out  WIDTH_BITS   to Controller.width, stable while running
//  iteration      out  ITER_BITS    to Controller.iteration, stable while running
//  finish         in   1            from Controller.finish
//  done_valid     out  1            result available
//  done_ready     in   1            result consumed when done_valid&done_ready
//  done_cycles    out  CYC_BITS     cycles running was high, finish cycle included
//  done_error     out  1            job was zero-sized, timed out or aborted
//  busy           out  1            state!=IDLE or FIFO non-empty
//  queue_level    out  QDEPTH_LOG2+1  FIFO occupancy
// BEHAVIOUR
//  Reset: running=0, width=0, iteration=0, done_valid=0, done_cycles=0, done_error=0.
//   FIFO is empty, job_ready=1, state=IDLE.
//  job_ready = !full and does not depend on a same-cycle pop. A push at full is ignored.
//   A push and a pop in the same cycle leave the level unchanged.
//  FSM IDLE->LAUNCH: FIFO non-empty and !abort. Pop the head.
//   Latch width/iteration into the output registers.
//  LAUNCH: if width==0 or iteration==0, go to REPORT with error=1 and cycles=0.
//   running is never raised for such a job. Otherwise raise running next cycle, go to RUN.
//   The counter loads 1.
//  RUN: counter increments each cycle (saturates at all-ones).
//   finish==1 -> running=0 next cycle, error=0, go to GAP.
//   Counter reaches TIMEOUT_CYCLES (nonzero) with no finish -> running=0, error=1, go to GAP.
//   If finish and timeout coincide, finish wins.
//  GAP: running held low for GAP_CYCLES, then go to REPORT.
//   finish pulses arriving in GAP are ignored.
//  REPORT: done_valid=1 with done_cycles/done_error held stable until done_ready.
//   No new launch happens while a result is pending (single-entry result).
//   On accept, done_valid=0 next cycle, go to IDLE.
//   The next LAUNCH follows IDLE no earlier than 1 cycle later.
//  abort (any state): flush the FIFO.
//   If in LAUNCH or RUN, drop running next cycle, error=1, go to GAP.
//   The aborted job is still reported. IDLE, GAP and REPORT are unaffected apart from the flush.
//   A push in the abort cycle is dropped.
//  width/iteration keep the last job's values after it ends. They change only in LAUNCH.
//  Invariant: running never rises within GAP_CYCLES of its previous fall.
// STRUCTURE
//  Shared package mv_pkg holds the FSM state enum (IDLE, LAUNCH, RUN, GAP, REPORT).
//   It also holds WIDTH_BITS/ITER_BITS defaults shared with the Controller.
//  Sub-module mv_job_fifo: synchronous FIFO of {width,iteration}.
//   It has first-word-fall-through head, a level output and a flush input.
//  Counter, gap timer and FSM live in the top module.
// TESTING
//  1) Push (17,3); Controller model pulses finish after 100 running cycles.
//     Expect done_cycles=100, done_error=0, running low for >=2 cycles.
//  2) Push (17,3),(24,3) back-to-back. Expect two launches in order.
//     Expect width 17 then 24 and exactly GAP_CYCLES+2 idle cycles between them when done_ready=1.
//  3) Push 5 jobs with QDEPTH_LOG2=2 and no pop. Expect job_ready=0 after 4.
//     The 5th is ignored and queue_level=4.
//  4) Push (0,3). Expect running never rises, done_valid with cycles=0, error=1.
//  5) TIMEOUT_CYCLES=50 with finish never asserted. Expect running to fall after 50 cycles.
//     Expect done_error=1, done_cycles=50.
//  6) Abort mid-RUN with 2 jobs queued. Expect running low next cycle, queue_level=0.
//     Expect one error result and none for the flushed jobs.
//     Also hold done_ready=0 for 10 cycles: fields stay stable and no launch occurs.

Source files
------------

// File: rtl/mv_pkg.sv
// mv_pkg: job-sequencer FSM states and the Controller field widths shared across fixed_mv.
package mv_pkg;
    localparam int MV_WIDTH_BITS = 9;
    localparam int MV_ITER_BITS  = 16;
    typedef enum logic [2:0] {IDLE, LAUNCH, RUN, GAP, REPORT} state_t;
endpackage

// File: rtl/mv_job_sequencer_if.sv
// mv_job_sequencer_if: host job channel, Controller handshake and result channel of the sequencer.
interface mv_job_sequencer_if #(
    parameter int QDEPTH_LOG2 = 2,
    parameter int WIDTH_BITS  = mv_pkg::MV_WIDTH_BITS,
    parameter int ITER_BITS   = mv_pkg::MV_ITER_BITS,
    parameter int CYC_BITS    = 32
);
    logic                   job_valid;
    logic                   job_ready;
    logic [WIDTH_BITS-1:0]  job_width;
    logic [ITER_BITS-1:0]   job_iteration;
    logic                   abort;
    logic                   running;
    logic [WIDTH_BITS-1:0]  width;
    logic [ITER_BITS-1:0]   iteration;
    logic                   finish;
    logic                   done_valid;
    logic                   done_ready;
    logic [CYC_BITS-1:0]    done_cycles;
    logic                   done_error;
    logic                   busy;
    logic [QDEPTH_LOG2:0]   queue_level;

    modport master (
        output job_valid, job_width, job_iteration, abort, finish, done_ready,
        input  job_ready, running, width, iteration, done_valid, done_cycles, done_error, busy, queue_level
    );
    modport slave (
        input  job_valid, job_width, job_iteration, abort, finish, done_ready,
        output job_ready, running, width, iteration, done_valid, done_cycles, done_error, busy, queue_level
    );
endinterface

// File: rtl/mv_job_fifo.sv
// mv_job_fifo: first-word-fall-through job FIFO with occupancy output and synchronous flush.
module mv_job_fifo #(
    parameter int DW = 25,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [DW-1:0] data_i,
    input  logic          pop_i,
    output logic [DW-1:0] data_o,
    output logic          empty_o,
    output logic          full_o,
    output logic [AW:0]   level_o
);
    logic [DW-1:0] mem_q [2**AW];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   lvl_q;
    logic          push, pop;

    assign full_o  = lvl_q[AW];
    assign empty_o = lvl_q == '0;
    assign level_o = lvl_q;
    assign data_o  = mem_q[rd_q];
    // flush outranks both ports, so a push in the flush cycle is lost
    assign push    = push_i && !full_o && !flush_i;
    assign pop     = pop_i && !empty_o && !flush_i;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
        end else begin
            wr_q  <= wr_q + AW'(push);
            rd_q  <= rd_q + AW'(pop);
            lvl_q <= lvl_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= data_i;
    end
endmodule

// File: rtl/mv_job_sequencer.sv
// mv_job_sequencer: queues mat-vec jobs, runs them one at a time on the Controller
// and reports each job's run-cycle count or error on a single-entry result port.
module mv_job_sequencer
    import mv_pkg::*;
#(
    parameter int QDEPTH_LOG2    = 2,
    parameter int WIDTH_BITS     = MV_WIDTH_BITS,
    parameter int ITER_BITS      = MV_ITER_BITS,
    parameter int CYC_BITS       = 32,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 0
) (
    input logic               clk,
    input logic               rstn,
    mv_job_sequencer_if.slave bus
);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    state_t                          state_q;
    logic                            running_q, done_valid_q, done_error_q;
    logic [WIDTH_BITS-1:0]           width_q;
    logic [ITER_BITS-1:0]            iter_q;
    logic [CYC_BITS-1:0]             cnt_q;
    logic [GW-1:0]                   gap_q;
    logic [WIDTH_BITS+ITER_BITS-1:0] head;
    logic                            empty, full, pop, timeout;

    assign pop     = state_q == IDLE && !empty && !bus.abort;
    assign timeout = TIMEOUT_CYCLES != 0 && cnt_q == CYC_BITS'(TIMEOUT_CYCLES);

    mv_job_fifo #(.DW(WIDTH_BITS + ITER_BITS), .AW(QDEPTH_LOG2)) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .flush_i (bus.abort),
        .push_i  (bus.job_valid),
        .data_i  ({bus.job_width, bus.job_iteration}),
        .pop_i   (pop),
        .data_o  (head),
        .empty_o (empty),
        .full_o  (full),
        .level_o (bus.queue_level)
    );

    assign bus.job_ready   = !full;
    assign bus.running     = running_q;
    assign bus.width       = width_q;
    assign bus.iteration   = iter_q;
    assign bus.done_valid  = done_valid_q;
    assign bus.done_cycles = cnt_q;
    assign bus.done_error  = done_error_q;
    assign bus.busy        = state_q != IDLE || !empty;

    // The GAP state is one cycle shorter than GAP_CYCLES (never below one): the REPORT
    // cycle completes the required low time, so back-to-back jobs see GAP_CYCLES+2 low cycles.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            running_q    <= 1'b0;
            width_q      <= '0;
            iter_q       <= '0;
            cnt_q        <= '0;
            gap_q        <= '0;
            done_valid_q <= 1'b0;
            done_error_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        width_q <= head[WIDTH_BITS+ITER_BITS-1:ITER_BITS];
                        iter_q  <= head[ITER_BITS-1:0];
                        state_q <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    if (bus.abort) begin
                        cnt_q        <= '0;
                        done_error_q <= 1'b1;
                        gap_q        <= GW'(GAP_CYCLES - 1);
                        state_q      <= GAP;
                    end else if (width_q == '0 || iter_q == '0) begin
                        cnt_q        <= '0;
                        done_error_q <= 1'b1;
                        done_valid_q <= 1'b1;
                        state_q      <= REPORT;
                    end else begin
                        cnt_q     <= CYC_BITS'(1);
                        running_q <= 1'b1;
                        state_q   <= RUN;
                    end
                end
                RUN: begin
                    if (bus.abort || bus.finish || timeout) begin
                        running_q    <= 1'b0;
                        done_error_q <= bus.abort || !bus.finish;
                        gap_q        <= GW'(GAP_CYCLES - 1);
                        state_q      <= GAP;
                    end else begin
                        cnt_q <= cnt_q + CYC_BITS'(cnt_q != '1);
                    end
                end
                GAP: begin
                    if (gap_q <= GW'(1)) begin
                        done_valid_q <= 1'b1;
                        state_q      <= REPORT;
                    end else begin
                        gap_q <= gap_q - GW'(1);
                    end
                end
                REPORT: begin
                    if (bus.done_ready) begin
                        done_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mv_job_sequencer.sv
// tb_mv_job_sequencer: randomized job-level checks against a queue-based host/Controller model.
module tb_mv_job_sequencer;
    localparam int QL = 2, WB = 9, IB = 16, CB = 32, GAP = 2, TO = 50;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mv_job_sequencer_if #(.QDEPTH_LOG2(QL), .WIDTH_BITS(WB), .ITER_BITS(IB), .CYC_BITS(CB)) b0 ();
    mv_job_sequencer_if #(.QDEPTH_LOG2(QL), .WIDTH_BITS(WB), .ITER_BITS(IB), .CYC_BITS(CB)) b1 ();

    mv_job_sequencer #(.QDEPTH_LOG2(QL), .WIDTH_BITS(WB), .ITER_BITS(IB), .CYC_BITS(CB),
                       .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(0)) dut (.clk(clk), .rstn(rstn), .bus(b0));
    mv_job_sequencer #(.QDEPTH_LOG2(QL), .WIDTH_BITS(WB), .ITER_BITS(IB), .CYC_BITS(CB),
                       .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut_to (.clk(clk), .rstn(rstn), .bus(b1));

    typedef struct {int w; int i; int low;} launch_t;
    launch_t launches[$];
    int      fin_q[$];
    int      cur0 = 0, rc0 = 0, low0 = 1000;
    logic    prev0 = 1'b0;

    // Controller model for b0: logs each launch, pulses finish on the N-th running cycle (0 = never)
    always @(negedge clk) begin
        if (b0.running && !prev0) begin
            launches.push_back('{int'(b0.width), int'(b0.iteration), low0});
            cur0 = 0;
            if (fin_q.size() != 0) cur0 = fin_q.pop_front();
        end
        rc0 = b0.running ? rc0 + 1 : 0;
        b0.finish = b0.running && cur0 != 0 && rc0 == cur0;
        low0 = b0.running ? 0 : low0 + 1;
        prev0 = b0.running;
    end

    task automatic push0(input int w, input int it);
        b0.job_valid = 1'b1;
        b0.job_width = WB'(w);
        b0.job_iteration = IB'(it);
        @(negedge clk);
        b0.job_valid = 1'b0;
    endtask

    task automatic wait_done0(input int limit, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < limit && !ok; n++) begin
            if (b0.done_valid) ok = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({b0.running, b0.done_valid, b0.done_error, b0.busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got %b want 0000", {b0.running, b0.done_valid, b0.done_error, b0.busy});
        end
        checks++;
        if (b0.width !== '0 || b0.iteration !== '0 || b0.done_cycles !== '0) begin
            errors++;
            $display("FAIL reset_fields got w=%0d i=%0d c=%0d want 0", b0.width, b0.iteration, b0.done_cycles);
        end
        checks++;
        if (b0.job_ready !== 1'b1 || b0.queue_level !== '0) begin
            errors++;
            $display("FAIL reset_queue got ready=%b level=%0d want 1/0", b0.job_ready, b0.queue_level);
        end
        checks++;
        if (b1.running !== 1'b0 || b1.done_valid !== 1'b0 || b1.job_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_timeout_inst got run=%b dv=%b rdy=%b want 0/0/1", b1.running, b1.done_valid, b1.job_ready);
        end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        bit ok = 1'b0, seen = 1'b0;
        int lows = 0;
        fin_q.delete();
        fin_q.push_back(100);
        push0(17, 3);
        for (int n = 0; n < 400 && !ok; n++) begin
            if (b0.running) seen = 1'b1;
            else if (seen) lows++;
            if (b0.done_valid) ok = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!ok || b0.done_cycles !== 32'd100 || b0.done_error !== 1'b0) begin
            errors++;
            $display("FAIL single_result got ok=%b c=%0d e=%b want 1/100/0", ok, b0.done_cycles, b0.done_error);
        end
        checks++;
        if (lows < GAP) begin
            errors++;
            $display("FAIL single_gap got %0d low cycles want >=%0d", lows, GAP);
        end
        checks++;
        if (b0.width !== 9'd17 || b0.iteration !== 16'd3) begin
            errors++;
            $display("FAIL single_operands got %0d/%0d want 17/3", b0.width, b0.iteration);
        end
        @(negedge clk);
        checks++;
        if (b0.done_valid !== 1'b0 || b0.busy !== 1'b0) begin
            errors++;
            $display("FAIL single_accept got dv=%b busy=%b want 0/0", b0.done_valid, b0.busy);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int f[2];
        f[0] = int'($urandom_range(5, 40));
        f[1] = int'($urandom_range(5, 40));
        launches.delete();
        fin_q.delete();
        fin_q.push_back(f[0]);
        fin_q.push_back(f[1]);
        b0.job_valid = 1'b1;
        b0.job_width = 9'd17;
        b0.job_iteration = 16'd3;
        @(negedge clk);
        b0.job_width = 9'd24;
        @(negedge clk);
        b0.job_valid = 1'b0;
        for (int j = 0; j < 2; j++) begin
            wait_done0(600, ok);
            checks++;
            if (!ok || b0.done_cycles !== CB'(f[j]) || b0.done_error !== 1'b0) begin
                errors++;
                $display("FAIL b2b_result%0d got ok=%b c=%0d e=%b want 1/%0d/0", j, ok, b0.done_cycles, b0.done_error, f[j]);
            end
            @(negedge clk);
        end
        checks++;
        if (launches.size() != 2) begin
            errors++;
            $display("FAIL b2b_launches got %0d want 2", launches.size());
        end else begin
            checks++;
            if (launches[0].w != 17 || launches[1].w != 24 || launches[0].i != 3 || launches[1].i != 3) begin
                errors++;
                $display("FAIL b2b_order got %0d,%0d want 17,24", launches[0].w, launches[1].w);
            end
            checks++;
            if (launches[1].low != GAP + 2) begin
                errors++;
                $display("FAIL b2b_gap got %0d want %0d", launches[1].low, GAP + 2);
            end
        end
    endtask

    task automatic test_random_jobs();
        int ew[$], ei[$], ef[$];
        bit ok;
        launches.delete();
        fin_q.delete();
        b0.done_ready = 1'b0;
        for (int j = 0; j < 4; j++) begin
            ew.push_back(int'($urandom_range(1, 511)));
            ei.push_back(int'($urandom_range(1, 65535)));
            ef.push_back(int'($urandom_range(1, 30)));
            fin_q.push_back(ef[j]);
            push0(ew[j], ei[j]);
        end
        for (int j = 0; j < 4; j++) begin
            wait_done0(800, ok);
            repeat ($urandom_range(0, 4)) @(negedge clk);
            checks++;
            if (!ok || b0.done_cycles !== CB'(ef[j]) || b0.done_error !== 1'b0) begin
                errors++;
                $display("FAIL rand_result%0d got ok=%b c=%0d e=%b want 1/%0d/0", j, ok, b0.done_cycles, b0.done_error, ef[j]);
            end
            checks++;
            if (launches.size() != j + 1) begin
                errors++;
                $display("FAIL rand_pending%0d got %0d launches want %0d", j, launches.size(), j + 1);
            end else begin
                checks++;
                if (launches[j].w != ew[j] || launches[j].i != ei[j]) begin
                    errors++;
                    $display("FAIL rand_operands%0d got %0d/%0d want %0d/%0d", j, launches[j].w, launches[j].i, ew[j], ei[j]);
                end
            end
            b0.done_ready = 1'b1;
            @(negedge clk);
            b0.done_ready = 1'b0;
        end
        b0.done_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_and_zero();
        bit ok;
        launches.delete();
        fin_q.delete();
        b0.done_ready = 1'b0;
        push0(0, 3);
        wait_done0(50, ok);
        checks++;
        if (!ok || b0.done_cycles !== '0 || b0.done_error !== 1'b1) begin
            errors++;
            $display("FAIL zero_width got ok=%b c=%0d e=%b want 1/0/1", ok, b0.done_cycles, b0.done_error);
        end
        for (int j = 0; j < 5; j++) begin
            checks++;
            if (b0.job_ready !== (j < 4)) begin
                errors++;
                $display("FAIL full_ready%0d got %b want %b", j, b0.job_ready, j < 4);
            end
            push0(j + 1, 7);
        end
        checks++;
        if (b0.queue_level !== 3'd4 || b0.job_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_level got %0d ready=%b want 4/0", b0.queue_level, b0.job_ready);
        end
        b0.abort = 1'b1;
        @(negedge clk);
        b0.abort = 1'b0;
        checks++;
        if (b0.queue_level !== '0 || b0.done_valid !== 1'b1 || b0.done_error !== 1'b1 || b0.busy !== 1'b1) begin
            errors++;
            $display("FAIL report_flush got lvl=%0d dv=%b e=%b busy=%b want 0/1/1/1", b0.queue_level, b0.done_valid, b0.done_error, b0.busy);
        end
        b0.done_ready = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (b0.done_valid !== 1'b0 || b0.busy !== 1'b0 || launches.size() != 0) begin
            errors++;
            $display("FAIL zero_no_run got dv=%b busy=%b launches=%0d want 0/0/0", b0.done_valid, b0.busy, launches.size());
        end
        push0(5, 0);
        wait_done0(50, ok);
        checks++;
        if (!ok || b0.done_cycles !== '0 || b0.done_error !== 1'b1 || launches.size() != 0) begin
            errors++;
            $display("FAIL zero_iter got ok=%b c=%0d e=%b launches=%0d want 1/0/1/0", ok, b0.done_cycles, b0.done_error, launches.size());
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        for (int k = 0; k < 2; k++) begin
            int hc = 0;
            bit ok = 1'b0;
            b1.job_valid = 1'b1;
            b1.job_width = 9'd17;
            b1.job_iteration = 16'd3;
            @(negedge clk);
            b1.job_valid = 1'b0;
            for (int n = 0; n < 300 && !ok; n++) begin
                if (b1.running) hc++;
                b1.finish = k == 1 && b1.running && hc == TO;
                if (b1.done_valid) ok = 1'b1;
                else @(negedge clk);
            end
            b1.finish = 1'b0;
            checks++;
            if (!ok || hc != TO) begin
                errors++;
                $display("FAIL timeout_run%0d got ok=%b high=%0d want 1/%0d", k, ok, hc, TO);
            end
            checks++;
            if (b1.done_cycles !== CB'(TO) || b1.done_error !== (k == 0)) begin
                errors++;
                $display("FAIL timeout_result%0d got c=%0d e=%b want %0d/%b", k, b1.done_cycles, b1.done_error, TO, k == 0);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_abort();
        bit ok;
        int hc = 0;
        int runlen = int'($urandom_range(3, 20));
        int wa = int'($urandom_range(1, 511));
        launches.delete();
        fin_q.delete();
        fin_q.push_back(0);
        b0.done_ready = 1'b0;
        push0(wa, 9);
        push0(33, 4);
        push0(44, 5);
        for (int n = 0; n < 200 && hc < runlen; n++) begin
            if (b0.running) hc++;
            if (hc < runlen) @(negedge clk);
        end
        checks++;
        if (hc != runlen || b0.queue_level !== 3'd2) begin
            errors++;
            $display("FAIL abort_setup got high=%0d lvl=%0d want %0d/2", hc, b0.queue_level, runlen);
        end
        b0.abort = 1'b1;
        b0.job_valid = 1'b1;
        b0.job_width = 9'd55;
        b0.job_iteration = 16'd6;
        @(negedge clk);
        b0.abort = 1'b0;
        b0.job_valid = 1'b0;
        checks++;
        if (b0.running !== 1'b0 || b0.queue_level !== '0) begin
            errors++;
            $display("FAIL abort_drop got run=%b lvl=%0d want 0/0", b0.running, b0.queue_level);
        end
        wait_done0(50, ok);
        checks++;
        if (!ok || b0.done_error !== 1'b1 || b0.done_cycles !== CB'(hc) || b0.width !== WB'(wa)) begin
            errors++;
            $display("FAIL abort_result got ok=%b e=%b c=%0d w=%0d want 1/1/%0d/%0d", ok, b0.done_error, b0.done_cycles, b0.width, hc, wa);
        end
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            checks++;
            if ({b0.done_valid, b0.done_error, b0.running} !== 3'b110 || b0.done_cycles !== CB'(hc) || launches.size() != 1) begin
                errors++;
                $display("FAIL abort_hold%0d got dv/e/run=%b c=%0d launches=%0d want 110/%0d/1", n,
                         {b0.done_valid, b0.done_error, b0.running}, b0.done_cycles, launches.size(), hc);
            end
        end
        b0.done_ready = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (b0.done_valid !== 1'b0 || b0.busy !== 1'b0 || launches.size() != 1) begin
            errors++;
            $display("FAIL abort_flushed got dv=%b busy=%b launches=%0d want 0/0/1", b0.done_valid, b0.busy, launches.size());
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        b0.job_valid = 1'b0;
        b0.job_width = '0;
        b0.job_iteration = '0;
        b0.abort = 1'b0;
        b0.done_ready = 1'b1;
        b1.job_valid = 1'b0;
        b1.job_width = '0;
        b1.job_iteration = '0;
        b1.abort = 1'b0;
        b1.done_ready = 1'b1;
        b1.finish = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_random_jobs();
        test_full_and_zero();
        test_timeout();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
